sdram_responder: RTL and testbench

Synthesizable SDR SDRAM device model: the memory-side counterpart of the SDRAM controller's pin interface. It decodes the controller's command bus (CS/RAS/CAS/WE, bank, multiplexed address), tracks open rows per bank, and services reads and writes from an internal block-RAM array. It honours the programmed CAS latency and burst length. It is used for on-FPGA loopback tests and for controller simulation without a vendor memory model.

---
 rtl/sdram_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device model for the controller pin interface.
// Decodes the command bus, tracks open rows per bank, honours CAS latency and
// burst length, and services reads/writes from an internal word array.
module sdram_responder #(
    parameter int MEM_AW   = 12,
    parameter int COL_KEEP = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_cs,
    input  logic        sdram_ras,
    input  logic        sdram_cas,
    input  logic        sdram_we,
    input  logic [1:0]  sdram_bank,
    input  logic [12:0] sdram_addr,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int ROW_W = MEM_AW - 2 - COL_KEEP;
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        BST_IDLE  = 2'd0,
        BST_READ  = 2'd1,
        BST_WRITE = 2'd2
    } burst_t;

    // Command decode
    logic [2:0] cmd;
    logic       cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr, cmd_bt;
    logic       bank_open, any_open, rd_go, wr_go;

    // Bank and mode state
    logic [3:0]       bank_act_q, bank_act_d;
    logic [ROW_W-1:0] bank_row_q [4];
    logic [ROW_W-1:0] bank_row_d [4];
    logic [1:0]       bl_q, bl_d;
    logic             cl3_q, cl3_d;

    // Burst tracking
    burst_t             bst_q, bst_d;
    logic [1:0]         bbank_q, bbank_d;
    logic [ROW_W-1:0]   brow_q, brow_d;
    logic [COL_KEEP-1:0] bcol_q, bcol_d;
    logic [2:0]         bcnt_q, bcnt_d;
    logic               bap_q, bap_d;

    // Read pipeline and outputs
    logic [2:0]  rvld_q, rvld_d;
    logic [15:0] rdat_q [3];
    logic        oe_q, oe_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        err_q, err_d;
    logic [2:0]  err_code_q, err_code_d;

    // Beat currently being serviced
    logic                beat_vld, beat_wr, beat_ap, beat_last;
    logic [1:0]          beat_bank;
    logic [ROW_W-1:0]    beat_row;
    logic [COL_KEEP-1:0] beat_start, beat_col, mask_c;
    logic [2:0]          beat_idx, bl_mask;
    logic [MEM_AW-1:0]   mem_addr;
    logic                mem_we, rd_issue, sel_vld;
    logic [15:0]         sel_dat;

    logic [15:0] mem [DEPTH];

    // Bits of the address bus that this geometry never looks at
    logic unused_addr;
    assign unused_addr = ^sdram_addr;

    assign sdram_dq_out = dq_out_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    // The controller drives DQ in a WRITE cycle, so release the bus at once
    assign sdram_dq_oe  = oe_q & ~wr_go;

    // Decode the command bus and gate READ/WRITE by bank state
    always_comb begin
        cmd       = {sdram_ras, sdram_cas, sdram_we};
        cmd_act   = !sdram_cs && (cmd == 3'b011);
        cmd_rd    = !sdram_cs && (cmd == 3'b101);
        cmd_wr    = !sdram_cs && (cmd == 3'b100);
        cmd_pre   = !sdram_cs && (cmd == 3'b010);
        cmd_ref   = !sdram_cs && (cmd == 3'b001);
        cmd_lmr   = !sdram_cs && (cmd == 3'b000);
        cmd_bt    = !sdram_cs && (cmd == 3'b110);
        bank_open = bank_act_q[sdram_bank];
        any_open  = |bank_act_q;
        rd_go     = cmd_rd && bank_open;
        wr_go     = cmd_wr && bank_open;
        case (bl_q)
            2'd0:    bl_mask = 3'd0;
            2'd1:    bl_mask = 3'd1;
            2'd2:    bl_mask = 3'd3;
            default: bl_mask = 3'd7;
        endcase
    end

    // Select the beat for this cycle: a new command wins over a running burst
    always_comb begin
        beat_vld   = 1'b0;
        beat_wr    = 1'b0;
        beat_bank  = bbank_q;
        beat_row   = brow_q;
        beat_start = bcol_q;
        beat_idx   = bcnt_q;
        beat_ap    = bap_q;
        if (rd_go || wr_go) begin
            beat_vld   = 1'b1;
            beat_wr    = wr_go;
            beat_bank  = sdram_bank;
            beat_row   = bank_row_q[sdram_bank];
            beat_start = sdram_addr[COL_KEEP-1:0];
            beat_idx   = 3'd0;
            beat_ap    = sdram_addr[10];
        end else if (bst_q != BST_IDLE) begin
            beat_vld = 1'b1;
            beat_wr  = (bst_q == BST_WRITE);
        end
        mask_c    = COL_KEEP'(bl_mask);
        beat_col  = (beat_start & ~mask_c) | ((beat_start + COL_KEEP'(beat_idx)) & mask_c);
        beat_last = (beat_idx == bl_mask);
        mem_addr  = {beat_bank, beat_row, beat_col};
        mem_we    = beat_vld && beat_wr && !cmd_bt;
        rd_issue  = beat_vld && !beat_wr;
        sel_vld   = cl3_q ? rvld_q[2] : rvld_q[1];
        sel_dat   = cl3_q ? rdat_q[2] : rdat_q[1];
    end

    // Next-state logic for banks, mode register, burst, read pipe and errors
    always_comb begin
        bank_act_d = bank_act_q;
        bank_row_d = bank_row_q;
        bl_d       = bl_q;
        cl3_d      = cl3_q;
        bst_d      = bst_q;
        bbank_d    = bbank_q;
        brow_d     = brow_q;
        bcol_d     = bcol_q;
        bcnt_d     = bcnt_q;
        bap_d      = bap_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        if (cmd_act) begin
            if (bank_open) begin
                err_d      = 1'b1;
                err_code_d = 3'd1;
            end else begin
                bank_act_d[sdram_bank] = 1'b1;
                bank_row_d[sdram_bank] = sdram_addr[ROW_W-1:0];
            end
        end else if ((cmd_rd || cmd_wr) && !bank_open) begin
            err_d      = 1'b1;
            err_code_d = 3'd2;
        end else if (cmd_pre) begin
            if (sdram_addr[10]) begin
                bank_act_d = 4'd0;
            end else begin
                bank_act_d[sdram_bank] = 1'b0;
            end
        end else if (cmd_ref && any_open) begin
            err_d      = 1'b1;
            err_code_d = 3'd3;
        end else if (cmd_lmr) begin
            if (any_open) begin
                err_d      = 1'b1;
                err_code_d = 3'd4;
            end else if (sdram_addr[3] || sdram_addr[2] ||
                         (sdram_addr[6:5] != 2'b01)) begin
                err_d      = 1'b1;
                err_code_d = 3'd5;
            end else begin
                bl_d  = sdram_addr[1:0];
                cl3_d = sdram_addr[4];
            end
        end

        if (rd_go || wr_go) begin
            bbank_d = sdram_bank;
            brow_d  = bank_row_q[sdram_bank];
            bcol_d  = sdram_addr[COL_KEEP-1:0];
            bap_d   = sdram_addr[10];
            bcnt_d  = 3'd1;
            if (beat_last) begin
                bst_d = BST_IDLE;
            end else begin
                bst_d = wr_go ? BST_WRITE : BST_READ;
            end
        end else if (bst_q != BST_IDLE) begin
            bcnt_d = bcnt_q + 3'd1;
            if (cmd_bt || beat_last) begin
                bst_d = BST_IDLE;
            end
        end

        // Auto-precharge closes the bank once the final beat has been serviced
        if (beat_vld && beat_last && beat_ap && !cmd_bt) begin
            bank_act_d[beat_bank] = 1'b0;
        end

        rvld_d   = wr_go ? 3'd0 : {rvld_q[1:0], rd_issue};
        oe_d     = sel_vld && !wr_go;
        dq_out_d = sel_vld ? sel_dat : dq_out_q;
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_act_q <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                bank_row_q[i] <= '0;
            end
            bl_q       <= 2'd0;
            cl3_q      <= 1'b0;
            bst_q      <= BST_IDLE;
            bbank_q    <= 2'd0;
            brow_q     <= '0;
            bcol_q     <= '0;
            bcnt_q     <= 3'd0;
            bap_q      <= 1'b0;
            rvld_q     <= 3'd0;
            oe_q       <= 1'b0;
            dq_out_q   <= 16'd0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            bank_act_q <= bank_act_d;
            bank_row_q <= bank_row_d;
            bl_q       <= bl_d;
            cl3_q      <= cl3_d;
            bst_q      <= bst_d;
            bbank_q    <= bbank_d;
            brow_q     <= brow_d;
            bcol_q     <= bcol_d;
            bcnt_q     <= bcnt_d;
            bap_q      <= bap_d;
            rvld_q     <= rvld_d;
            oe_q       <= oe_d;
            dq_out_q   <= dq_out_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Word array and read-data delay line; writes are blocked while in reset
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_addr] <= sdram_dq_in;
        end
        rdat_q[0] <= mem[mem_addr];
        rdat_q[1] <= rdat_q[0];
        rdat_q[2] <= rdat_q[1];
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed scenarios plus randomized command
// streams, all checked against a queue-based behavioural model.
module tb_sdram_responder;

    localparam int MEM_AW    = 12;
    localparam int COL_KEEP  = 6;
    localparam int BANK_SPAN = 1 << (MEM_AW - 2);
    localparam int ROWS      = 1 << (MEM_AW - 2 - COL_KEEP);
    localparam int COLS      = 1 << COL_KEEP;
    localparam int NEXP      = 8192;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_BT  = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
    logic [1:0]  bank = 2'd0;
    logic [12:0] addr = 13'd0;
    logic [15:0] dq_in = 16'd0;
    logic [15:0] dq_out;
    logic        oe, err;
    logic [2:0]  code;

    always #5 clk = ~clk;

    sdram_responder #(.MEM_AW(MEM_AW), .COL_KEEP(COL_KEEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .sdram_cs(cs), .sdram_ras(ras), .sdram_cas(cas), .sdram_we(we),
        .sdram_bank(bank), .sdram_addr(addr), .sdram_dq_in(dq_in),
        .sdram_dq_out(dq_out), .sdram_dq_oe(oe),
        .err(err), .err_code(code)
    );

    typedef struct {
        int  addr;
        bit  wr;
        bit  ap;
        int  bank;
        bit  last;
    } beat_t;

    int          total = 0;
    int          bad = 0;
    int          cnt = 0;
    bit          m_open [4];
    int          m_row [4];
    int          m_bl, m_cl, m_code;
    bit          m_err;
    logic [15:0] mm [int];
    bit          exp_v [NEXP];
    bit          exp_k [NEXP];
    logic [15:0] exp_d [NEXP];
    beat_t       pend [$];
    int          seen_e [$];
    logic [15:0] seen_d [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (edge %0d)", tag, got, want, cnt);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
        end
        m_bl = 1; m_cl = 2; m_err = 1'b0; m_code = 0;
        pend.delete();
        mm.delete();
        for (int t = 0; t < NEXP; t++) exp_v[t] = 1'b0;
    endtask

    // Effects of the command sampled at the coming edge (index cnt+1)
    task automatic model_edge(input logic c_cs, input logic [2:0] c, input logic [1:0] b,
                              input logic [12:0] a, input logic [15:0] d);
        int    n, start, base;
        bit    bt, anyo;
        beat_t bb;
        n    = cnt + 1;
        bt   = 1'b0;
        anyo = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        if (!c_cs) begin
            case (c)
                C_ACT: if (m_open[b]) begin m_err = 1'b1; m_code = 1; end
                       else begin m_open[b] = 1'b1; m_row[b] = int'(a); end
                C_RD, C_WR: begin
                    if (!m_open[b]) begin
                        m_err = 1'b1; m_code = 2;
                    end else begin
                        if (c == C_WR)
                            for (int t = n; t < n + 8 && t < NEXP; t++) exp_v[t] = 1'b0;
                        pend.delete();
                        start = int'(a[9:0]);
                        base  = start - (start % m_bl);
                        for (int k = 0; k < m_bl; k++) begin
                            bb.addr = int'(b) * BANK_SPAN + (m_row[b] % ROWS) * COLS
                                      + ((base + (start + k) % m_bl) % COLS);
                            bb.wr   = (c == C_WR);
                            bb.ap   = a[10];
                            bb.bank = int'(b);
                            bb.last = (k == m_bl - 1);
                            pend.push_back(bb);
                        end
                    end
                end
                C_PRE: if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
                       else m_open[b] = 1'b0;
                C_REF: if (anyo) begin m_err = 1'b1; m_code = 3; end
                C_LMR: begin
                    if (anyo) begin
                        m_err = 1'b1; m_code = 4;
                    end else if (a[3] || a[2] || !(a[6:4] == 3'd2 || a[6:4] == 3'd3)) begin
                        m_err = 1'b1; m_code = 5;
                    end else begin
                        m_bl = 1 << a[1:0];
                        m_cl = int'(a[6:4]);
                    end
                end
                C_BT: bt = 1'b1;
                default: ;
            endcase
        end
        if (pend.size() > 0) begin
            bb = pend.pop_front();
            if (bb.wr) begin
                if (!bt) mm[bb.addr] = d;
            end else if (n + m_cl < NEXP) begin
                exp_v[n + m_cl] = 1'b1;
                exp_k[n + m_cl] = mm.exists(bb.addr);
                exp_d[n + m_cl] = mm.exists(bb.addr) ? mm[bb.addr] : 16'd0;
            end
            if (!bt && bb.last && bb.ap) m_open[bb.bank] = 1'b0;
            if (bt) pend.delete();
        end
    endtask

    // Drive one command, check outputs for the current edge, advance one cycle
    task automatic step(input logic c_cs, input logic [2:0] c, input logic [1:0] b,
                        input logic [12:0] a, input logic [15:0] d);
        bit wv, eo;
        cs = c_cs; {ras, cas, we} = c; bank = b; addr = a; dq_in = d;
        #1;
        wv = !c_cs && (c == C_WR) && m_open[b];
        eo = exp_v[cnt] && !wv;
        chk("oe", 32'(oe), 32'(eo));
        if (eo && exp_k[cnt]) chk("dq", 32'(dq_out), 32'(exp_d[cnt]));
        chk("err", 32'(err), 32'(m_err));
        chk("err_code", 32'(code), 32'(m_code));
        if (oe) begin
            seen_e.push_back(cnt);
            seen_d.push_back(dq_out);
        end
        model_edge(c_cs, c, b, a, d);
        @(posedge clk);
        cnt++;
        @(negedge clk);
    endtask

    task automatic nop(input int k);
        for (int i = 0; i < k; i++) step(1'b1, C_NOP, 2'd0, 13'd0, 16'd0);
    endtask
    task automatic nopd(input logic [15:0] d);
        step(1'b1, C_NOP, 2'd0, 13'd0, d);
    endtask
    task automatic act(input logic [1:0] b, input logic [12:0] row);
        step(1'b0, C_ACT, b, row, 16'd0);
    endtask
    task automatic rd(input logic [1:0] b, input logic [9:0] col, input logic ap);
        step(1'b0, C_RD, b, {2'b00, ap, col}, 16'd0);
    endtask
    task automatic wr(input logic [1:0] b, input logic [9:0] col, input logic ap, input logic [15:0] d);
        step(1'b0, C_WR, b, {2'b00, ap, col}, d);
    endtask
    task automatic pre_all();
        step(1'b0, C_PRE, 2'd0, 13'h400, 16'd0);
    endtask
    task automatic lmr(input logic [12:0] op);
        step(1'b0, C_LMR, 2'd0, op, 16'd0);
    endtask
    task automatic clear_seen();
        seen_e.delete();
        seen_d.delete();
    endtask

    initial begin
        int r_edge, r, rb, rcol;
        logic [15:0] w8 [8];
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_dq", 32'(dq_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        rst_n = 1'b1;

        // CL2/BL4 write then read back
        lmr(13'h022);
        act(2'd1, 13'd5);
        wr(2'd1, 10'd0, 1'b0, 16'h00A0);
        nopd(16'h00A1); nopd(16'h00A2); nopd(16'h00A3);
        clear_seen();
        rd(2'd1, 10'd0, 1'b0);
        r_edge = cnt;
        nop(6);
        chk("t1_beats", 32'(seen_d.size()), 32'd4);
        chk("t1_first_edge", 32'(seen_e[0]), 32'(r_edge + 2));
        for (int i = 0; i < 4; i++) chk("t1_data", 32'(seen_d[i]), 32'h00A0 + 32'(i));
        chk("t1_err", 32'(err), 32'd0);

        // CL3/BL8 with wrap inside the aligned block
        pre_all();
        lmr(13'h033);
        act(2'd1, 13'd5);
        wr(2'd1, 10'd8, 1'b0, 16'd0);
        for (int k = 1; k < 8; k++) nopd(16'(k));
        clear_seen();
        rd(2'd1, 10'd13, 1'b0);
        r_edge = cnt;
        nop(12);
        w8 = '{16'd5, 16'd6, 16'd7, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
        chk("t2_beats", 32'(seen_d.size()), 32'd8);
        chk("t2_first_edge", 32'(seen_e[0]), 32'(r_edge + 3));
        for (int i = 0; i < 8; i++) chk("t2_data", 32'(seen_d[i]), 32'(w8[i]));

        // Read of an idle bank, then ACTIVE on an open bank
        clear_seen();
        rd(2'd2, 10'd0, 1'b0);
        nop(4);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_code", 32'(code), 32'd2);
        chk("t3_no_oe", 32'(seen_d.size()), 32'd0);
        act(2'd1, 13'd7);
        chk("t3_act_code", 32'(code), 32'd1);

        // Burst terminate one cycle after a BL4 read
        pre_all();
        lmr(13'h022);
        act(2'd1, 13'd5);
        clear_seen();
        rd(2'd1, 10'd0, 1'b0);
        step(1'b0, C_BT, 2'd0, 13'd0, 16'd0);
        nop(6);
        chk("t4_beats", 32'(seen_d.size()), 32'd2);
        chk("t4_d0", 32'(seen_d[0]), 32'h00A0);
        chk("t4_d1", 32'(seen_d[1]), 32'h00A1);

        // LOAD MODE with a bank open is rejected and CL stays 2
        act(2'd0, 13'd1);
        lmr(13'h030);
        chk("t5_code", 32'(code), 32'd4);
        clear_seen();
        rd(2'd1, 10'd0, 1'b0);
        r_edge = cnt;
        nop(6);
        chk("t5_first_edge", 32'(seen_e[0]), 32'(r_edge + 2));
        chk("t5_beats", 32'(seen_d.size()), 32'd4);
        pre_all();
        step(1'b0, C_REF, 2'd0, 13'd0, 16'd0);
        nop(1);
        chk("t5_ref_code", 32'(code), 32'd4);

        // Reset during the second beat of a CL3 read
        pre_all();
        lmr(13'h033);
        act(2'd1, 13'd5);
        rd(2'd1, 10'd8, 1'b0);
        nop(4);
        chk("t6_pre_oe", 32'(oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_oe", 32'(oe), 32'd0);
        chk("t6_dq", 32'(dq_out), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_code", 32'(code), 32'd0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        act(2'd1, 13'd5);
        wr(2'd1, 10'd3, 1'b0, 16'h1234);
        clear_seen();
        rd(2'd1, 10'd3, 1'b0);
        r_edge = cnt;
        nop(4);
        chk("t6_beats", 32'(seen_d.size()), 32'd1);
        chk("t6_data", 32'(seen_d[0]), 32'h1234);
        chk("t6_first_edge", 32'(seen_e[0]), 32'(r_edge + 2));

        // Randomized command streams under every legal mode
        for (int m = 0; m < 8; m++) begin
            step(1'b0, C_BT, 2'd0, 13'd0, 16'd0);
            pre_all();
            nop(5);
            lmr(13'(((2 + m / 4) << 4) | (m % 4)));
            for (int i = 0; i < 120; i++) begin
                r    = $urandom_range(0, 99);
                rb   = $urandom_range(0, 3);
                rcol = $urandom_range(0, 15);
                if (r < 30)      nopd(16'($urandom));
                else if (r < 50) rd(2'(rb), 10'(rcol), ($urandom_range(0, 3) == 0));
                else if (r < 70) wr(2'(rb), 10'(rcol), ($urandom_range(0, 3) == 0), 16'($urandom));
                else if (r < 82) act(2'(rb), 13'($urandom_range(0, 31)));
                else if (r < 92) step(1'b0, C_PRE, 2'(rb), {2'b00, ($urandom_range(0, 2) == 0), 10'd0}, 16'd0);
                else if (r < 96) step(1'b0, C_BT, 2'd0, 13'd0, 16'($urandom));
                else             step(1'b0, C_REF, 2'd0, 13'd0, 16'd0);
            end
        end
        nop(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
